// File: rtl/project_pkg.sv
// Shared project types: matrix element type, ASCII byte constants and the
// state encoding of the matrix element sender.
package project_pkg;

    typedef logic signed [7:0] matrix_element_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_I     = 8'h49;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_TX,
        S_DONE
    } sender_state_t;

endpackage

// File: rtl/matrix_elem_sender_digits.sv
// elem_to_digits: splits an 8-bit unsigned magnitude into decimal digits and
// reports how many digits are significant (1..3, zero counts as one digit).
module elem_to_digits (
    input  logic [7:0] magnitude,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] digit_count
);

    logic [7:0] rem;

    always_comb begin
        hundreds = 4'(magnitude / 8'd100);
        rem      = magnitude % 8'd100;
        tens     = 4'(rem / 8'd10);
        ones     = 4'(rem % 8'd10);
        if (magnitude >= 8'd100)
            digit_count = 2'd3;
        else if (magnitude >= 8'd10)
            digit_count = 2'd2;
        else
            digit_count = 2'd1;
    end

endmodule

// File: rtl/matrix_elem_sender.sv
// matrix_elem_sender: prints one matrix element, "ID=<n>" or a bare CR LF as
// ASCII bytes over the uart_tx handshake. Define SENDER_PAD_EN for right-aligned elements.
module matrix_elem_sender
    import project_pkg::*;
#(
    parameter int PAD_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  matrix_element_t sender_data,
    input  logic            sender_start,
    input  logic            sender_is_last_col,
    input  logic            sender_newline_only,
    input  logic            sender_id,
    output logic            sender_done,
    output logic            busy,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_done
);

`ifdef SENDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    localparam int BUF_N = (PAD_EN && (PAD_W + 2 > 8)) ? PAD_W + 2 : 8;

    sender_state_t       state;
    matrix_element_t     data_q;
    logic                last_q;
    logic                nl_q;
    logic                id_q;
    logic [BUF_N*8-1:0]  buf_q;
    logic [3:0]          len_q;
    logic [3:0]          idx;

    logic                neg;
    logic [7:0]          magnitude;
    logic [3:0]          hundreds;
    logic [3:0]          tens;
    logic [3:0]          ones;
    logic [1:0]          digit_count;
    logic [BUF_N*8-1:0]  nxt_buf;
    logic [3:0]          nxt_len;

    // ID mode prints the raw byte unsigned; otherwise -128 negates to 0x80 = 128.
    assign neg       = !id_q && data_q[7];
    assign magnitude = neg ? 8'(-data_q) : 8'(data_q);

    elem_to_digits u_digits (
        .magnitude   (magnitude),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones),
        .digit_count (digit_count)
    );

    always_comb begin
        int n;
        nxt_buf = '0;
        n       = 0;
        if (nl_q) begin
            nxt_buf[0 +: 8] = ASCII_CR;
            nxt_buf[8 +: 8] = ASCII_LF;
            n = 2;
        end else begin
            if (id_q) begin
                nxt_buf[0  +: 8] = ASCII_I;
                nxt_buf[8  +: 8] = ASCII_D;
                nxt_buf[16 +: 8] = ASCII_EQ;
                n = 3;
            end
`ifdef SENDER_PAD_EN
            if (!id_q) begin
                for (int i = 0; i < PAD_W; i++) begin
                    if (i < PAD_W - (int'(neg) + int'(digit_count))) begin
                        nxt_buf[n*8 +: 8] = ASCII_SP;
                        n = n + 1;
                    end
                end
            end
`endif
            if (neg) begin
                nxt_buf[n*8 +: 8] = ASCII_MINUS;
                n = n + 1;
            end
            if (digit_count == 2'd3) begin
                nxt_buf[n*8 +: 8] = ASCII_0 + {4'd0, hundreds};
                n = n + 1;
            end
            if (digit_count >= 2'd2) begin
                nxt_buf[n*8 +: 8] = ASCII_0 + {4'd0, tens};
                n = n + 1;
            end
            nxt_buf[n*8 +: 8] = ASCII_0 + {4'd0, ones};
            n = n + 1;
            if (last_q) begin
                nxt_buf[n*8 +: 8]     = ASCII_CR;
                nxt_buf[(n+1)*8 +: 8] = ASCII_LF;
                n = n + 2;
            end else begin
                nxt_buf[n*8 +: 8] = ASCII_SP;
                n = n + 1;
            end
        end
        nxt_len = 4'(n);
    end

    // tx_data/tx_start are loaded on the transition into SEND so both are
    // registered and valid together for the whole SEND cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            data_q      <= '0;
            last_q      <= 1'b0;
            nl_q        <= 1'b0;
            id_q        <= 1'b0;
            buf_q       <= '0;
            len_q       <= '0;
            idx         <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            sender_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            sender_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (sender_start) begin
                        data_q <= sender_data;
                        last_q <= sender_is_last_col;
                        nl_q   <= sender_newline_only;
                        id_q   <= sender_id;
                        busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    buf_q    <= nxt_buf;
                    len_q    <= nxt_len;
                    idx      <= '0;
                    tx_data  <= nxt_buf[7:0];
                    tx_start <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        if (idx == len_q - 4'd1) begin
                            sender_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            idx      <= idx + 4'd1;
                            tx_data  <= buf_q[(int'(idx) + 1)*8 +: 8];
                            tx_start <= 1'b1;
                            state    <= S_SEND;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_elem_sender.sv
// Directed bench for matrix_elem_sender with a uart_tx responder model that
// acknowledges each byte three cycles after its tx_start.
module tb_matrix_elem_sender;
    import project_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    matrix_element_t sender_data = '0;
    logic            sender_start = 1'b0;
    logic            sender_is_last_col = 1'b0;
    logic            sender_newline_only = 1'b0;
    logic            sender_id = 1'b0;
    logic            sender_done;
    logic            busy;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_done;
    logic            model_done = 1'b0;
    logic            inject_done = 1'b0;

    logic [7:0] captured[$];
    int done_count = 0;
    int pending = 0;
    int vectors = 0;
    int miscompares = 0;

    assign tx_done = model_done | inject_done;

    always #5 clk = ~clk;

    matrix_elem_sender dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sender_data         (sender_data),
        .sender_start        (sender_start),
        .sender_is_last_col  (sender_is_last_col),
        .sender_newline_only (sender_newline_only),
        .sender_id           (sender_id),
        .sender_done         (sender_done),
        .busy                (busy),
        .tx_data             (tx_data),
        .tx_start            (tx_start),
        .tx_done             (tx_done)
    );

    // uart_tx stand-in: capture each byte, pulse tx_done three edges later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else begin
                if (pending > 0) begin
                    pending = pending - 1;
                    if (pending == 0) model_done = 1'b1;
                end
                if (tx_start) begin
                    captured.push_back(tx_data);
                    pending = 2;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sender_done) done_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, miscompares %0d", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            if (sender_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkBytes(input string tag, input logic [63:0] exp, input int len);
        logic [31:0] obs;
        checkOutput({tag, ".len"}, 32'(captured.size()), 32'(len));
        for (int i = 0; i < len; i++) begin
            obs = (i < captured.size()) ? 32'(captured[i]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("%s.b%0d", tag, i), obs, 32'(exp[63-8*i -: 8]));
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] data, input logic last,
                                 input logic nl, input logic id, input logic [63:0] exp, input int len);
        bit ok;
        captured.delete();
        done_count = 0;
        @(posedge clk);
        #2;
        sender_data         = matrix_element_t'(data);
        sender_is_last_col  = last;
        sender_newline_only = nl;
        sender_id           = id;
        sender_start        = 1'b1;
        @(posedge clk);
        #2;
        sender_start = 1'b0;
        checkOutput({tag, ".busy_load"}, 32'(busy), 32'd1);
        waitDone(ok);
        checkOutput({tag, ".done_seen"}, 32'(ok), 32'd1);
        checkOutput({tag, ".busy_done"}, 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        checkOutput({tag, ".done_count"}, 32'(done_count), 32'd1);
        checkOutput({tag, ".busy_idle"}, 32'(busy), 32'd0);
        checkBytes(tag, exp, len);
    endtask

    initial begin
        bit ok;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst.tx_start", 32'(tx_start), 32'd0);
        checkOutput("rst.tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.sender_done", 32'(sender_done), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        applyStimulus("neg128", 8'h80, 1'b1, 1'b0, 1'b0, 64'h2D31_3238_0D0A_0000, 6);
`ifdef SENDER_PAD_EN
        applyStimulus("zero", 8'h00, 1'b0, 1'b0, 1'b0, 64'h2020_2030_2000_0000, 5);
        applyStimulus("pos127", 8'h7F, 1'b0, 1'b0, 1'b0, 64'h2031_3237_2000_0000, 5);
        applyStimulus("neg5", 8'hFB, 1'b1, 1'b0, 1'b0, 64'h2020_2D35_0D0A_0000, 6);
        applyStimulus("pos10", 8'h0A, 1'b0, 1'b0, 1'b0, 64'h2020_3130_2000_0000, 5);
`else
        applyStimulus("zero", 8'h00, 1'b0, 1'b0, 1'b0, 64'h3020_0000_0000_0000, 2);
        applyStimulus("pos127", 8'h7F, 1'b0, 1'b0, 1'b0, 64'h3132_3720_0000_0000, 4);
        applyStimulus("neg5", 8'hFB, 1'b1, 1'b0, 1'b0, 64'h2D35_0D0A_0000_0000, 4);
        applyStimulus("pos10", 8'h0A, 1'b0, 1'b0, 1'b0, 64'h3130_2000_0000_0000, 3);
`endif
        applyStimulus("id7", 8'h07, 1'b1, 1'b0, 1'b1, 64'h4944_3D37_0D0A_0000, 6);
        applyStimulus("id200", 8'hC8, 1'b1, 1'b0, 1'b1, 64'h4944_3D32_3030_0D0A, 8);
        applyStimulus("id255", 8'hFF, 1'b0, 1'b0, 1'b1, 64'h4944_3D32_3535_2000, 7);
        applyStimulus("prio", 8'd99, 1'b0, 1'b1, 1'b1, 64'h0D0A_0000_0000_0000, 2);

        // second start, stray tx_done and changing inputs during LOAD/SEND
        captured.delete();
        done_count = 0;
        @(posedge clk);
        #2;
        sender_data         = 8'sd42;
        sender_is_last_col  = 1'b0;
        sender_newline_only = 1'b0;
        sender_id           = 1'b0;
        sender_start        = 1'b1;
        @(posedge clk);
        #2;
        sender_data         = 8'sd1;
        sender_is_last_col  = 1'b1;
        sender_newline_only = 1'b1;
        sender_id           = 1'b1;
        inject_done         = 1'b1;
        checkOutput("robust.load_tx_start", 32'(tx_start), 32'd0);
        @(posedge clk);
        #2;
        sender_start = 1'b0;
        checkOutput("robust.first_tx_start", 32'(tx_start), 32'd1);
`ifdef SENDER_PAD_EN
        checkOutput("robust.first_tx_data", 32'(tx_data), 32'h20);
`else
        checkOutput("robust.first_tx_data", 32'(tx_data), 32'h34);
`endif
        @(posedge clk);
        #2;
        inject_done = 1'b0;
        waitDone(ok);
        checkOutput("robust.done_seen", 32'(ok), 32'd1);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("robust.done_count", 32'(done_count), 32'd1);
`ifdef SENDER_PAD_EN
        checkBytes("robust", 64'h2020_3432_2000_0000, 5);
`else
        checkBytes("robust", 64'h3432_2000_0000_0000, 3);
`endif

        // reset after the second byte has gone out
        sender_newline_only = 1'b0;
        sender_id           = 1'b0;
        captured.delete();
        done_count = 0;
        @(posedge clk);
        #2;
        sender_data        = -8'sd128;
        sender_is_last_col = 1'b1;
        sender_start       = 1'b1;
        @(posedge clk);
        #2;
        sender_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            if (captured.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("midrst.two_bytes", 32'(ok), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst.tx_start", 32'(tx_start), 32'd0);
        checkOutput("midrst.tx_data", 32'(tx_data), 32'd0);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        checkOutput("midrst.sender_done", 32'(sender_done), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        checkOutput("midrst.no_done", 32'(done_count), 32'd0);
        checkOutput("midrst.no_more_bytes", 32'(captured.size()), 32'd2);
`ifdef SENDER_PAD_EN
        applyStimulus("after_rst", 8'h03, 1'b0, 1'b0, 1'b0, 64'h2020_2033_2000_0000, 5);
`else
        applyStimulus("after_rst", 8'h03, 1'b0, 1'b0, 1'b0, 64'h3320_0000_0000_0000, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
